change_dispenser: RTL and testbench

Output side of the vending datapath. It takes the credit total built up by the coin accumulator and a product price, then either vends and returns change or refunds the full credit. Change goes out as single-cycle 500/100 coin pulses, largest coin first. A 7-segment display shows the change still owed.

---
 rtl/change_dispenser.sv | 140 ++++++++++++++
 tb/tb_change_dispenser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//   Output side of the vending datapath. Accepts a credit total and a price,
//   then either vends and pays change, or refunds the full credit. Change is
//   paid as single-cycle 500/100 coin pulses, largest coin first. Amounts are
//   in units of 100.
// Ports
//   seconds      system clock, rising edge
//   rst          synchronous active-high reset
//   start        request a transaction (sampled only while idle)
//   cancel       with start: refund full credit, no vend
//   credit       accumulated credit, latched on accepted start
//   price        product price, latched on accepted start
//   vend         one-cycle product-release pulse
//   coin500_out  one-cycle pulse, eject one 500 coin
//   coin100_out  one-cycle pulse, eject one 100 coin
//   busy         high whenever a transaction is in progress
//   done         one-cycle pulse at transaction end
//   error        credit < price, held from acceptance to end of DONE
//   display      active-low {g..a} hex digit of the change still owed
module change_dispenser #(
  parameter int unsigned BITS = 4
) (
  input  logic            seconds,
  input  logic            rst,
  input  logic            start,
  input  logic            cancel,
  input  logic [BITS-1:0] credit,
  input  logic [BITS-1:0] price,
  output logic            vend,
  output logic            coin500_out,
  output logic            coin100_out,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [6:0]      display
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VEND = 2'd1,
    PAY  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [BITS-1:0] change, change_nx;
  logic            err_q, err_nx;
  logic [BITS-1:0] paid;
  logic [3:0]      digit;

  always_ff @(posedge seconds) begin
    if (rst) begin
      state  <= IDLE;
      change <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      change <= change_nx;
      err_q  <= err_nx;
    end
  end

  // Change remaining after this PAY cycle's coin; a zero refund pays nothing.
  always_comb begin
    paid = '0;
    if (change >= BITS'(5))
      paid = change - BITS'(5);
    else if (change != '0)
      paid = change - BITS'(1);
  end

  always_comb begin
    state_nx  = state;
    change_nx = change;
    err_nx    = err_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cancel) begin
            change_nx = credit;
            err_nx    = 1'b0;
            state_nx  = PAY;
          end else if (credit < price) begin
            change_nx = credit;
            err_nx    = 1'b1;
            state_nx  = PAY;
          end else begin
            change_nx = credit - price;
            err_nx    = 1'b0;
            state_nx  = VEND;
          end
        end
      end
      VEND: state_nx = (change != '0) ? PAY : DONE;
      PAY: begin
        change_nx = paid;
        if (paid == '0)
          state_nx = DONE;
      end
      DONE: begin
        err_nx   = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign vend        = (state == VEND);
  assign coin500_out = (state == PAY) && (change >= BITS'(5));
  assign coin100_out = (state == PAY) && (change < BITS'(5)) && (change != '0);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign error       = err_q;

  assign digit = 4'(change);

  always_comb begin
    display = 7'b1000000;
    unique case (digit)
      4'h0: display = 7'b1000000;
      4'h1: display = 7'b1111001;
      4'h2: display = 7'b0100100;
      4'h3: display = 7'b0110000;
      4'h4: display = 7'b0011001;
      4'h5: display = 7'b0010010;
      4'h6: display = 7'b0000010;
      4'h7: display = 7'b1111000;
      4'h8: display = 7'b0000000;
      4'h9: display = 7'b0010000;
      4'hA: display = 7'b0001000;
      4'hB: display = 7'b0000011;
      4'hC: display = 7'b1000110;
      4'hD: display = 7'b0100001;
      4'hE: display = 7'b0000110;
      4'hF: display = 7'b0001110;
      default: display = 7'b1000000;
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Bench for change_dispenser. A transaction-level model turns each accepted
//   start into a list of expected per-cycle outputs, and a compare process
//   checks the DUT against it every cycle. Directed transactions pin the model
//   with hand-computed pulse counts and lengths; a random phase follows.
module tb_change_dispenser;

  logic       seconds = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] credit = '0;
  logic [3:0] price = '0;
  logic       vend, coin500_out, coin100_out, busy, done, error;
  logic [6:0] display;

  int vectors = 0;
  int miscompares = 0;
  logic checking = 1'b0;

  change_dispenser #(.BITS(4)) dut (
    .seconds    (seconds),
    .rst        (rst),
    .start      (start),
    .cancel     (cancel),
    .credit     (credit),
    .price      (price),
    .vend       (vend),
    .coin500_out(coin500_out),
    .coin100_out(coin100_out),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .display    (display)
  );

  always #5 seconds = ~seconds;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic       vend;
    logic       c500;
    logic       c100;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] chg;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected cycle list for one transaction: optional vend cycle, one cycle
  // per coin (largest first), then the done cycle.
  task automatic plan(input logic [3:0] cr, input logic [3:0] pr, input logic cn);
    int   amt;
    logic e;
    exp_t r;
    e   = !cn && (cr < pr);
    amt = (cn || e) ? int'(cr) : int'(cr) - int'(pr);
    if (!cn && !e) begin
      r = '0; r.vend = 1; r.busy = 1; r.err = e; r.chg = 4'(amt);
      q.push_back(r);
    end else if (amt == 0) begin
      r = '0; r.busy = 1; r.err = e; r.chg = 0;
      q.push_back(r);
    end
    while (amt > 0) begin
      r = '0; r.busy = 1; r.err = e; r.chg = 4'(amt);
      if (amt >= 5) begin r.c500 = 1; amt -= 5; end
      else          begin r.c100 = 1; amt -= 1; end
      q.push_back(r);
    end
    r = '0; r.busy = 1; r.done = 1; r.err = e; r.chg = 0;
    q.push_back(r);
  endtask

  always @(posedge seconds) begin
    if (rst) begin
      q.delete();
      cur = '0;
    end else if (!cur.busy) begin
      if (start) begin
        plan(credit, price, cancel);
        cur = q.pop_front();
      end else begin
        cur = '0;
      end
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
  end

  always @(negedge seconds) begin
    if (checking)
      chk("cycle", int'({vend, coin500_out, coin100_out, busy, done, error, display}),
          int'({cur.vend, cur.c500, cur.c100, cur.busy, cur.done, cur.err, seg_tab[cur.chg]}));
  end

  task automatic run_txn(input logic [3:0] cr, input logic [3:0] pr, input logic cn,
                         input int ev, input int e5, input int e1, input int eerr,
                         input int elen, input logic poke);
    int n, v, c5, c1, se;
    logic fin;
    @(negedge seconds);
    start = 1; cancel = cn; credit = cr; price = pr;
    @(negedge seconds);
    start = 0; cancel = 0; credit = 4'($urandom); price = 4'($urandom);
    n = 0; v = 0; c5 = 0; c1 = 0; se = 0; fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      n++;
      v += int'(vend); c5 += int'(coin500_out); c1 += int'(coin100_out);
      if (error) se = 1;
      if (done) fin = 1;
      else begin
        @(negedge seconds);
        // A start attempt while busy must not disturb the running sequence.
        start = poke && (i == 1);
        credit = 4'hF; cancel = 0;
      end
    end
    start = 0;
    chk("txn_done_seen", int'(fin), 1);
    chk("txn_vend", v, ev);
    chk("txn_coin500", c5, e5);
    chk("txn_coin100", c1, e1);
    chk("txn_error", se, eerr);
    chk("txn_len", n, elen);
  endtask

  initial begin
    repeat (2) @(negedge seconds);
    rst = 0;
    checking = 1;
    chk("reset_display", int'(display), int'(7'b1000000));
    chk("reset_busy", int'(busy), 0);

    run_txn(4'd3, 4'd3, 0, 1, 0, 0, 0, 2, 0);   // exact change
    run_txn(4'd10, 4'd1, 0, 1, 1, 4, 0, 7, 0);  // mixed change
    run_txn(4'd2, 4'd6, 0, 0, 0, 2, 1, 3, 0);   // insufficient credit
    @(negedge seconds);
    chk("error_cleared", int'(error), 0);
    run_txn(4'd6, 4'd2, 1, 0, 1, 1, 0, 3, 0);   // cancel
    run_txn(4'd0, 4'd0, 1, 0, 0, 0, 0, 2, 0);   // zero refund
    run_txn(4'd15, 4'd0, 0, 1, 3, 0, 0, 5, 1);  // max change, start poked while busy
    run_txn(4'd9, 4'd2, 0, 1, 1, 2, 0, 5, 0);   // accepted right after previous

    // Reset after the first coin of a 10/1 transaction.
    begin
      int c, k;
      @(negedge seconds);
      start = 1; credit = 4'd10; price = 4'd1; cancel = 0;
      @(negedge seconds);
      start = 0;
      k = 0;
      while (!coin500_out && k < 10) begin @(negedge seconds); k++; end
      chk("mid_reset_reached_pay", int'(coin500_out), 1);
      rst = 1;
      @(negedge seconds);
      rst = 0;
      chk("mid_reset_outputs", int'({vend, coin500_out, coin100_out, busy, done, error}), 0);
      chk("mid_reset_display", int'(display), int'(7'b1000000));
      c = 0;
      repeat (10) begin @(negedge seconds); c += int'(coin500_out) + int'(coin100_out); end
      chk("mid_reset_no_coins", c, 0);
    end

    // Random phase; the per-cycle compare covers it.
    repeat (3000) begin
      @(negedge seconds);
      rst    = ($urandom_range(0, 99) == 0);
      start  = ($urandom_range(0, 2) == 0);
      cancel = ($urandom_range(0, 3) == 0);
      credit = 4'($urandom);
      price  = 4'($urandom);
    end
    @(negedge seconds);
    rst = 0; start = 0;
    repeat (25) @(negedge seconds);
    chk("final_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
